// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared segment encodings and index-width helper for the scan mux
package seven_seg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seven_seg_digit_decode.sv
// seven_seg_digit_decode: BCD nibble to active-high a..g segments, non-decimal nibbles blank
module seven_seg_digit_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  // table lookup; A..F fall through to blank
  always_comb begin
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seven_seg_scan_mux.sv
// seven_seg_scan_mux: frame-synchronous double-buffered multi-digit seven-segment scanner
module seven_seg_scan_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [4*NUM_DIGITS-1:0]             io_digits,
  input  logic                                io_load,
  input  logic                                io_lzb,
  output logic [6:0]                          io_segOut,
  output logic [NUM_DIGITS-1:0]               io_anode,
  output logic [idx_width(NUM_DIGITS)-1:0]    io_digitIdx,
  output logic                                io_frameStart
);
  localparam int IW = idx_width(NUM_DIGITS);
  localparam int PW = idx_width(REFRESH_DIV);
  localparam int W  = 4 * NUM_DIGITS;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [W-1:0]          disp_q, disp_d, pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  tc, wrap;
  logic [3:0]            cur;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] nz, nz_sh;
  assign tc   = presc_q == PW'(REFRESH_DIV - 1);
  assign wrap = tc && idx_q == IW'(NUM_DIGITS - 1);
  // nz[k]: some displayed digit at position k or above is non-zero
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nz
    assign nz[g] = |disp_q[W-1:4*g];
  end
  // scan counters advance; buffered word is swapped in only on the frame wrap
  always_comb begin
    presc_d      = tc ? '0 : presc_q + 1'b1;
    idx_d        = tc ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
    disp_d       = wrap ? (io_load ? io_digits : (pend_valid_q ? pend_q : disp_q)) : disp_q;
    pend_d       = (io_load && !wrap) ? io_digits : pend_q;
    pend_valid_d = wrap ? 1'b0 : (io_load ? 1'b1 : pend_valid_q);
  end
  // state register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end
  assign cur = 4'(disp_q >> {idx_q, 2'b00});
  seven_seg_digit_decode u_dec (
    .bcd_i (cur),
    .seg_o (seg)
  );
  // digit 0 is never blanked so an all-zero word still shows "0"
  always_comb begin
    nz_sh         = nz >> idx_q;
    io_segOut     = (io_lzb && idx_q != '0 && !nz_sh[0]) ? SEG_BLANK : seg;
    io_anode      = NUM_DIGITS'(1) << idx_q;
    io_digitIdx   = idx_q;
    io_frameStart = idx_q == '0 && presc_q == '0;
  end
endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// tb_seven_seg_scan_mux: scoreboard bench for the scan mux (4 digits/div 4, plus 1 digit/div 1)
module tb_seven_seg_scan_mux;
  localparam int N  = 4;
  localparam int RD = 4;
  localparam int FR = N * RD;
  logic        clock = 1'b0;
  logic        reset, io_load, io_lzb;
  logic [15:0] io_digits;
  logic [6:0]  io_segOut, seg2;
  logic [3:0]  io_anode;
  logic [1:0]  io_digitIdx;
  logic        io_frameStart, an2, ix2, fs2;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fs;
    logic [1:0] ix;
    logic [6:0] seg2;
  } exp_t;
  exp_t        sb[$];
  int          n_cmp = 0, n_bad = 0;
  int          m_cyc;
  logic [15:0] m_disp, m_next;
  bit          m_has;
  logic [3:0]  m1_disp;
  always #5 clock = ~clock;
  seven_seg_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(RD)) dut (
    .clock(clock), .reset(reset), .io_digits(io_digits), .io_load(io_load), .io_lzb(io_lzb),
    .io_segOut(io_segOut), .io_anode(io_anode), .io_digitIdx(io_digitIdx), .io_frameStart(io_frameStart)
  );
  seven_seg_scan_mux #(.NUM_DIGITS(1), .REFRESH_DIV(1)) dut1 (
    .clock(clock), .reset(reset), .io_digits(io_digits[3:0]), .io_load(io_load), .io_lzb(io_lzb),
    .io_segOut(seg2), .io_anode(an2), .io_digitIdx(ix2), .io_frameStart(fs2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at model cycle %0d: got %0h expected %0h", tag, m_cyc, got, exp);
    end
  endtask
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    return tbl[d];
  endfunction
  function automatic exp_t expect_now(input bit lz);
    exp_t e;
    int   ix = (m_cyc / RD) % N;
    logic [15:0] upper = m_disp >> (4 * ix);
    e.an   = 4'(1 << ix);
    e.seg  = (lz && ix > 0 && upper == 16'h0) ? 7'h00 : seg_of(upper[3:0]);
    e.fs   = (m_cyc % FR) == 0;
    e.ix   = 2'(ix);
    e.seg2 = seg_of(m1_disp);
    return e;
  endfunction
  task automatic step(input bit ld, input logic [15:0] dg, input bit lz, input bit rs);
    exp_t e;
    @(negedge clock);
    reset = rs; io_load = ld; io_digits = dg; io_lzb = lz;
    if (rs) begin
      m_cyc = 0; m_disp = '0; m_has = 0; m1_disp = '0;
    end else begin
      if (m_cyc % FR == FR - 1) begin
        if (ld) m_disp = dg;
        else if (m_has) m_disp = m_next;
        m_has = 0;
      end else if (ld) begin
        m_next = dg; m_has = 1;
      end
      if (ld) m1_disp = dg[3:0];
      m_cyc++;
    end
    sb.push_back(expect_now(lz));
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check("anode", 32'(io_anode), 32'(e.an));
    check("seg", 32'(io_segOut), 32'(e.seg));
    check("frameStart", 32'(io_frameStart), 32'(e.fs));
    check("digitIdx", 32'(io_digitIdx), 32'(e.ix));
    check("n1_seg", 32'(seg2), 32'(e.seg2));
    check("n1_anode_fs", {30'd0, an2, fs2}, 32'h3);
    check("n1_idx", 32'(ix2), 32'h0);
  endtask
  task automatic idle(input int n, input bit lz);
    for (int i = 0; i < n; i++) step(0, 16'h0, lz, 0);
  endtask
  task automatic idle_to(input int ph, input bit lz);
    for (int i = 0; i < FR && (m_cyc % FR) != ph; i++) step(0, 16'h0, lz, 0);
  endtask
  initial begin
    m_cyc = 0; m_disp = '0; m_has = 0; m1_disp = '0; m_next = '0;
    step(0, 16'h0, 0, 1);
    step(0, 16'h0, 0, 1);
    check("rst_anode", 32'(io_anode), 32'h1);
    check("rst_seg", 32'(io_segOut), 32'h7E);
    check("rst_fs", 32'(io_frameStart), 32'h1);
    idle(4, 0);
    check("c4_anode", 32'(io_anode), 32'h2);
    idle(1, 0);
    step(1, 16'h1234, 0, 0);
    idle(9, 0);
    check("c15_still_old", 32'(io_segOut), 32'h7E);
    idle(1, 0);
    check("c16_fs", 32'(io_frameStart), 32'h1);
    check("c16_d0", 32'(io_segOut), 32'h33);
    idle(12, 0);
    check("d3_of_1234", 32'(io_segOut), 32'h30);
    step(1, 16'h0070, 0, 0);
    idle_to(0, 1);
    idle(FR, 1);
    step(1, 16'h0000, 1, 0);
    idle_to(0, 1);
    idle(FR, 1);
    idle(3, 0);
    step(1, 16'h1111, 0, 0);
    idle(5, 0);
    step(1, 16'h2222, 0, 0);
    idle_to(0, 0);
    check("last_load_wins", 32'(io_segOut), 32'h6D);
    idle(FR, 0);
    idle(2, 0);
    step(1, 16'h8888, 0, 0);
    idle_to(FR - 1, 0);
    step(1, 16'h5555, 0, 0);
    check("wrap_load_prio", 32'(io_segOut), 32'h5B);
    idle(FR + 2, 0);
    step(1, 16'hA9F0, 0, 0);
    idle_to(0, 0);
    idle(FR, 0);
    idle(6, 1);
    step(1, 16'h4444, 0, 0);
    idle(2, 0);
    step(0, 16'h0, 0, 1);
    check("midrst_anode", 32'(io_anode), 32'h1);
    idle(2 * FR, 0);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
